shared_exunit_arbiter: RTL

Shares one non-pipelined, multi-cycle execution unit (mul/div class) between two in-order reservation stations. Produces each station's `exunit_busynext` gate, accepts at most one issue per cycle, and tracks the in-flight operation's occupancy with a countdown. It also tracks the operation's speculative tag, so a branch mispredict kills the operation and a branch resolution clears its dependency. It sits between the two stations' issue logic and the unit's operand latch / result writeback.

---
 rtl/shared_exunit_arbiter_pkg.sv | 15 +
 rtl/exunit_occupancy_counter.sv | 54 +++++
 rtl/shared_exunit_arbiter.sv | 73 +++++++
 3 files changed

// File: rtl/shared_exunit_arbiter_pkg.sv
// Shared constants and types for the two-station multi-cycle execution unit arbiter.
package shared_exunit_arbiter_pkg;

  localparam int unsigned SPECTAG_LEN = 5;

  localparam int unsigned LATENCY_DFLT = 4;
  localparam int unsigned CNTW_DFLT    = 3;

  // Reservation station identifier, also used as the round-robin favourite.
  typedef enum logic {
    RS0 = 1'b0,
    RS1 = 1'b1
  } rs_sel_e;

endpackage

// File: rtl/exunit_occupancy_counter.sv
// Occupancy tracker for the shared unit: busy flag, countdown, owner and speculative tag.
module exunit_occupancy_counter #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned CNTW        = 3,
  parameter int unsigned SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   load_sel,
  input  logic [SPECTAG_LEN-1:0] load_tag,
  input  logic                   kill,
  input  logic                   fix,
  input  logic [SPECTAG_LEN-1:0] fix_mask,
  output logic                   busy,
  output logic                   occupied,
  output logic                   done,
  output logic                   sel,
  output logic [SPECTAG_LEN-1:0] tag
);

  logic                   busy_q;
  logic [CNTW-1:0]        cnt_q;
  logic                   sel_q;
  logic [SPECTAG_LEN-1:0] tag_q;

  assign occupied = busy_q && (cnt_q != '0);
  assign done     = busy_q && (cnt_q == '0) && !kill;
  assign busy     = busy_q;
  assign sel      = sel_q;
  assign tag      = tag_q;

  // A load in the done cycle overrides the release; kill freezes count and tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      sel_q  <= 1'b0;
      tag_q  <= '0;
    end else if (load) begin
      busy_q <= 1'b1;
      cnt_q  <= CNTW'(LATENCY - 1);
      sel_q  <= load_sel;
      tag_q  <= fix ? (load_tag & ~fix_mask) : load_tag;
    end else if (kill) begin
      busy_q <= 1'b0;
    end else begin
      if (occupied) cnt_q <= cnt_q - CNTW'(1);
      if (done) busy_q <= 1'b0;
      if (fix) tag_q <= tag_q & ~fix_mask;
    end
  end

endmodule

// File: rtl/shared_exunit_arbiter.sv
// Round-robin arbiter sharing one non-pipelined multi-cycle unit between two stations.
module shared_exunit_arbiter #(
  parameter int unsigned LATENCY     = shared_exunit_arbiter_pkg::LATENCY_DFLT,
  parameter int unsigned CNTW        = shared_exunit_arbiter_pkg::CNTW_DFLT,
  parameter int unsigned SPECTAG_LEN = shared_exunit_arbiter_pkg::SPECTAG_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   issue0,
  input  logic                   issue1,
  input  logic [SPECTAG_LEN-1:0] spectag0,
  input  logic [SPECTAG_LEN-1:0] spectag1,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  output logic                   exunit_busynext0,
  output logic                   exunit_busynext1,
  output logic                   start,
  output logic                   startsel,
  output logic                   done,
  output logic                   donesel,
  output logic                   busy,
  output logic [SPECTAG_LEN-1:0] spectag_out
);

  import shared_exunit_arbiter_pkg::*;

  rs_sel_e                prio_q;
  logic                   occupied;
  logic                   kill;
  logic [SPECTAG_LEN-1:0] load_tag;

  assign start    = issue0 | issue1;
  assign startsel = issue1;
  assign load_tag = issue1 ? spectag1 : spectag0;
  assign kill     = prmiss & busy & (|(spectag_out & prtag));

  // Gates see only registered state and raw req, never issuevalid.
  assign exunit_busynext0 = occupied | (req1 & (prio_q == RS1));
  assign exunit_busynext1 = occupied | (req0 & (prio_q == RS0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= RS0;
    end else if (start) begin
      prio_q <= startsel ? RS0 : RS1;
    end
  end

  exunit_occupancy_counter #(
    .LATENCY     (LATENCY),
    .CNTW        (CNTW),
    .SPECTAG_LEN (SPECTAG_LEN)
  ) u_occupancy (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_sel (startsel),
    .load_tag (load_tag),
    .kill     (kill),
    .fix      (prsuccess),
    .fix_mask (specfixtag),
    .busy     (busy),
    .occupied (occupied),
    .done     (done),
    .sel      (donesel),
    .tag      (spectag_out)
  );

endmodule
